river_puzzle: RTL and testbench

Parametrised river-crossing puzzle engine, the successor to the fixed wolf/sheep/cabbage `wsc` block. It is generalised to N items, a configurable boat capacity and an arbitrary "eats" conflict matrix. It adds a ready/valid command port, legality checking, sticky fail/win status, a move counter, and a bounded undo history. It sits under a testbench or solver FSM that issues crossings and watches `state`, `error` and `done`.

---
 rtl/river_pkg.sv | 24 ++
 rtl/river_puzzle_if.sv | 23 ++
 rtl/move_hist.sv | 59 +++++
 rtl/river_puzzle.sv | 125 ++++++++++++
 tb/tb_river_puzzle.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/river_pkg.sv
// Shared types and helpers for the river-crossing puzzle engine.
package river_pkg;

  typedef enum logic [1:0] {
    PLAY,
    FAIL,
    WIN
  } fsm_t;

  // Wolf(2) eats sheep(1), sheep(1) eats cabbage(0).
  localparam logic [8:0] WSC_CONFLICT = 9'h088;

  localparam int unsigned POP_W = 32;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/river_puzzle_if.sv
// Command handshake between a puzzle driver (master) and the engine (slave).
interface river_puzzle_if #(
  parameter int unsigned N_ITEMS = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_undo;
  logic [N_ITEMS-1:0] cmd_sel;

  modport master (
    output cmd_valid,
    output cmd_undo,
    output cmd_sel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_undo,
    input  cmd_sel,
    output cmd_ready
  );
endinterface

// File: rtl/move_hist.sv
// Circular LIFO of accepted moves; a push when full overwrites the oldest entry.
module move_hist #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  top_q;  // next slot to write
  logic [FILL_W-1:0] fill_q;
  logic [PTR_W-1:0]  prev_top;
  logic [PTR_W-1:0]  next_top;

  always_comb begin
    prev_top = (top_q == '0) ? LAST_IDX : top_q - PTR_ONE;
    next_top = (top_q == LAST_IDX) ? '0 : top_q + PTR_ONE;
  end

  assign dout  = mem[prev_top];
  assign empty = (fill_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q  <= '0;
      fill_q <= '0;
    end else if (clear) begin
      top_q  <= '0;
      fill_q <= '0;
    end else if (push) begin
      top_q  <= next_top;
      fill_q <= (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
    end else if (pop && !empty) begin
      top_q  <= prev_top;
      fill_q <= fill_q - FILL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[top_q] <= din;
    end
  end

endmodule

// File: rtl/river_puzzle.sv
// Generalised river-crossing engine: legality check, conflict/win status, move count and undo.
module river_puzzle
  import river_pkg::*;
#(
  parameter int unsigned                   N_ITEMS    = 3,
  parameter int unsigned                   CAPACITY   = 1,
  parameter logic [N_ITEMS*N_ITEMS-1:0]    CONFLICT   = WSC_CONFLICT,
  parameter int unsigned                   UNDO_DEPTH = 4,
  parameter int unsigned                   CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  river_puzzle_if.slave        cmd,
  output logic [N_ITEMS:0]     state,
  output logic                 error,
  output logic                 done,
  output logic                 illegal,
  output logic [CNT_W-1:0]     move_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fsm_t               fsm_q, fsm_d;
  logic [N_ITEMS:0]   state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               error_q, done_q, illegal_q, illegal_d;

  logic               accept;
  logic               farmer;
  logic [N_ITEMS-1:0] off_bank;
  logic               move_ok;
  logic               hist_push, hist_pop, hist_empty;
  logic [N_ITEMS-1:0] hist_dout;
  logic               conflict;

  assign cmd.cmd_ready = (fsm_q != WIN) & ~restart;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  // Selected items sitting on the opposite bank from the farmer.
  assign farmer   = state_q[N_ITEMS];
  assign off_bank = cmd.cmd_sel & (state_q[N_ITEMS-1:0] ^ {N_ITEMS{farmer}});
  assign move_ok  = (fsm_q == PLAY) && (off_bank == '0) &&
                    (popcount(POP_W'(cmd.cmd_sel)) <= CAPACITY);

  assign hist_push = accept & ~cmd.cmd_undo & move_ok;
  assign hist_pop  = accept & cmd.cmd_undo & ~hist_empty;

  move_hist #(
    .WIDTH (N_ITEMS),
    .DEPTH (UNDO_DEPTH)
  ) u_move_hist (
    .clk   (clk),
    .rst   (rst),
    .push  (hist_push),
    .pop   (hist_pop),
    .clear (restart),
    .din   (cmd.cmd_sel),
    .dout  (hist_dout),
    .empty (hist_empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    if (hist_push) begin
      state_d = state_q ^ {1'b1, cmd.cmd_sel};
      if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    end else if (hist_pop) begin
      state_d = state_q ^ {1'b1, hist_dout};
      if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
    end else if (accept) begin
      illegal_d = 1'b1;
    end
  end

  // Status is judged on the state that will be registered this edge.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      for (int unsigned j = 0; j < N_ITEMS; j++) begin
        if (CONFLICT[i*N_ITEMS+j] && (state_d[i] == state_d[j]) &&
            (state_d[i] != state_d[N_ITEMS])) begin
          conflict = 1'b1;
        end
      end
    end
    if (conflict)        fsm_d = FAIL;
    else if (&state_d)   fsm_d = WIN;
    else                 fsm_d = PLAY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= PLAY;
      state_q   <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (restart) begin
      fsm_q     <= PLAY;
      state_q   <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      error_q   <= (fsm_d == FAIL);
      done_q    <= (fsm_d == WIN);
      illegal_q <= illegal_d;
    end
  end

  assign state      = state_q;
  assign move_count = cnt_q;
  assign error      = error_q;
  assign done       = done_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_river_puzzle.sv
// Directed bench for river_puzzle: per-cycle model comparison plus hand-computed spot checks.
module tb_river_puzzle;

  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam int CAP   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic [3:0] state;
  logic       error, done, illegal;
  logic [7:0] move_count;

  always #5 clk = ~clk;

  river_puzzle_if #(.N_ITEMS(N)) cmd_if ();

  river_puzzle dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .cmd        (cmd_if),
    .state      (state),
    .error      (error),
    .done       (done),
    .illegal    (illegal),
    .move_count (move_count)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: banks per item, a move history queue, and an "eats" table.
  bit         m_farmer;
  bit         m_bank [N];
  logic [2:0] m_hist [$];
  int         m_count;
  bit         m_fail, m_win, m_illegal;
  bit         eats [N][N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_vec();
    return {m_farmer, m_bank[2], m_bank[1], m_bank[0]};
  endfunction

  task automatic model_reset();
    m_farmer = 0;
    for (int i = 0; i < N; i++) m_bank[i] = 0;
    m_hist.delete();
    m_count = 0;
    m_fail = 0;
    m_win = 0;
    m_illegal = 0;
  endtask

  task automatic model_step(input bit v, input bit u, input logic [2:0] s, input bit rs);
    bit ok, conflict, all_far;
    int n;
    logic [2:0] p;
    m_illegal = 0;
    if (rs) begin
      model_reset();
      return;
    end
    if (v && !m_win) begin
      if (u) begin
        if (m_hist.size() == 0) m_illegal = 1;
        else begin
          p = m_hist.pop_back();
          m_farmer = !m_farmer;
          for (int i = 0; i < N; i++) if (p[i]) m_bank[i] = !m_bank[i];
          if (m_count > 0) m_count--;
        end
      end else begin
        ok = !m_fail;
        n = 0;
        for (int i = 0; i < N; i++) begin
          if (s[i]) begin
            n++;
            if (m_bank[i] != m_farmer) ok = 0;
          end
        end
        if (n > CAP) ok = 0;
        if (ok) begin
          m_farmer = !m_farmer;
          for (int i = 0; i < N; i++) if (s[i]) m_bank[i] = !m_bank[i];
          m_hist.push_back(s);
          if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
          if (m_count < 255) m_count++;
        end else m_illegal = 1;
      end
    end
    conflict = 0;
    all_far  = m_farmer;
    for (int i = 0; i < N; i++) begin
      if (!m_bank[i]) all_far = 0;
      for (int j = 0; j < N; j++)
        if (eats[i][j] && m_bank[i] == m_bank[j] && m_bank[i] != m_farmer) conflict = 1;
    end
    m_fail = conflict;
    m_win  = !conflict && all_far;
  endtask

  // One compare process: every cycle, 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("cyc_state", {28'd0, state}, {28'd0, m_vec()});
      check("cyc_error", {31'd0, error}, {31'd0, m_fail});
      check("cyc_done", {31'd0, done}, {31'd0, m_win});
      check("cyc_illegal", {31'd0, illegal}, {31'd0, m_illegal});
      check("cyc_count", {24'd0, move_count}, 32'(m_count));
      check("cyc_ready", {31'd0, cmd_if.cmd_ready}, {31'd0, (!m_win && !restart)});
    end
  end

  task automatic drive(input bit v, input bit u, input logic [2:0] s, input bit rs);
    @(negedge clk);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_undo  = u;
    cmd_if.cmd_sel   = s;
    restart          = rs;
    @(posedge clk);
    model_step(v, u, s, rs);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_if.cmd_valid = 0;
    cmd_if.cmd_undo  = 0;
    cmd_if.cmd_sel   = '0;
    restart          = 0;
  endtask

  logic [2:0] sels [7] = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
  logic [3:0] exps [7] = '{4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111};
  logic [3:0] wrap_cnt [5] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd2};
  logic       wrap_ill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    eats[2][1] = 1;
    eats[1][0] = 1;
    model_reset();
    idle_inputs();
    #1 rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    chk_en = 1;
    #1;
    check("rst_state", {28'd0, state}, 32'h0);
    check("rst_error", {31'd0, error}, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);
    check("rst_illegal", {31'd0, illegal}, 32'h0);
    check("rst_count", {24'd0, move_count}, 32'h0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'h1);

    // Classic solve
    for (int k = 0; k < 7; k++) begin
      drive(1, 0, sels[k], 0);
      check("solve_state", {28'd0, state}, {28'd0, exps[k]});
    end
    check("solve_done", {31'd0, done}, 32'h1);
    check("solve_count", {24'd0, move_count}, 32'd7);
    check("solve_ready", {31'd0, cmd_if.cmd_ready}, 32'h0);
    drive(1, 0, 3'b100, 0);
    check("win_hold", {28'd0, state}, 32'hF);
    check("win_noill", {31'd0, illegal}, 32'h0);

    // Restart racing a command
    @(negedge clk);
    cmd_if.cmd_valid = 1;
    cmd_if.cmd_undo  = 0;
    cmd_if.cmd_sel   = 3'b010;
    restart          = 1;
    #1;
    check("race_ready", {31'd0, cmd_if.cmd_ready}, 32'h0);
    @(posedge clk);
    model_step(1, 0, 3'b010, 1);
    #1;
    check("race_state", {28'd0, state}, 32'h0);
    check("race_count", {24'd0, move_count}, 32'h0);

    // Fail then undo
    drive(1, 0, 3'b001, 0);
    check("fail_state", {28'd0, state}, 32'h9);
    check("fail_error", {31'd0, error}, 32'h1);
    drive(1, 0, 3'b100, 0);
    check("fail_move_ill", {31'd0, illegal}, 32'h1);
    drive(1, 1, 3'b000, 0);
    check("undo_state", {28'd0, state}, 32'h0);
    check("undo_error", {31'd0, error}, 32'h0);
    check("undo_count", {24'd0, move_count}, 32'h0);

    // Illegal moves
    drive(1, 0, 3'b011, 0);
    check("cap_ill", {31'd0, illegal}, 32'h1);
    check("cap_state", {28'd0, state}, 32'h0);
    drive(1, 0, 3'b010, 0);
    check("mv_state", {28'd0, state}, 32'hA);
    drive(1, 0, 3'b100, 0);
    check("bank_ill", {31'd0, illegal}, 32'h1);
    check("bank_state", {28'd0, state}, 32'hA);
    check("bank_count", {24'd0, move_count}, 32'h1);

    // History wrap
    drive(0, 0, 3'b000, 1);
    for (int k = 0; k < 6; k++) drive(1, 0, 3'b010, 0);
    check("wrap_count6", {24'd0, move_count}, 32'd6);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 3'b000, 0);
      check("wrap_undo_cnt", {24'd0, move_count}, {28'd0, wrap_cnt[k]});
      check("wrap_undo_ill", {31'd0, illegal}, {31'd0, wrap_ill[k]});
    end

    // Async reset mid-game from 0100
    drive(0, 0, 3'b000, 1);
    for (int k = 0; k < 4; k++) drive(1, 0, sels[k], 0);
    check("mid_state", {28'd0, state}, 32'h4);
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 0;
    model_reset();
    #1;
    check("arst_state", {28'd0, state}, 32'h0);
    check("arst_count", {24'd0, move_count}, 32'h0);
    check("arst_flags", {29'd0, error, done, illegal}, 32'h0);
    check("arst_ready", {31'd0, cmd_if.cmd_ready}, 32'h1);
    @(negedge clk);
    rst = 1;
    drive(1, 0, 3'b010, 0);
    check("post_state", {28'd0, state}, 32'hA);
    drive(0, 0, 3'b000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
